// File: rtl/dpram_if.sv
// dpram_if: port A/B access signals and status flags of dpram_param
interface dpram_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 16
);
    logic enable_port_a, enable_port_b, write_port_a, write_port_b;
    logic [DATA_W/8-1:0] byte_en_port_a, byte_en_port_b;
    logic [ADDR_W-1:0] address_port_a, address_port_b;
    logic [DATA_W-1:0] data_in_port_a, data_in_port_b;
    logic [DATA_W-1:0] data_out_port_a, data_out_port_b;
    logic rd_valid_port_a, rd_valid_port_b, busy, collision, addr_err;
    modport master (
        output enable_port_a, enable_port_b, write_port_a, write_port_b,
        output byte_en_port_a, byte_en_port_b, address_port_a, address_port_b,
        output data_in_port_a, data_in_port_b,
        input data_out_port_a, data_out_port_b, rd_valid_port_a, rd_valid_port_b,
        input busy, collision, addr_err
    );
    modport slave (
        input enable_port_a, enable_port_b, write_port_a, write_port_b,
        input byte_en_port_a, byte_en_port_b, address_port_a, address_port_b,
        input data_in_port_a, data_in_port_b,
        output data_out_port_a, data_out_port_b, rd_valid_port_a, rd_valid_port_b,
        output busy, collision, addr_err
    );
endinterface

// File: rtl/dpram_param.sv
// dpram_param: parametrised true dual-port RAM with byte enables, 1/2-cycle read pipeline,
// collision / range flags and a post-reset clear sequencer
module dpram_param #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 16,
    parameter int DEPTH = 1024,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic clk,
    input logic rst_n,
    dpram_if.slave bus
);
    localparam int NB = DATA_W / 8;
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    typedef enum logic {CLEAR, READY} state_t;
    state_t state, state_nx;
    logic [AW-1:0] cnt, cnt_nx, idx_a, idx_b;
    logic [DATA_W-1:0] mem [DEPTH];
    logic ready, in_a, in_b, rd_a, rd_b, wr_a, wr_b, coll, aerr;
    logic [DATA_W-1:0] old_a, old_b, rdat_a, rdat_b;
    logic v1_a, v1_b, c1, e1, v2_a, v2_b, c2, e2;
    logic [DATA_W-1:0] d1_a, d1_b, d2_a, d2_b;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old, din,
                                                 input logic [NB-1:0] be);
        logic [DATA_W-1:0] r;
        r = old;
        for (int i = 0; i < NB; i++) if (be[i]) r[i*8 +: 8] = din[i*8 +: 8];
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= CLEAR_ON_RESET != 0 ? CLEAR : READY;
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
        end

    always_comb begin
        state_nx = state == CLEAR && cnt == LAST ? READY : state;
        cnt_nx = state == CLEAR ? cnt + AW'(1) : cnt;
    end

    assign ready = state == READY;
    assign bus.busy = state == CLEAR;
    assign idx_a = bus.address_port_a[AW-1:0];
    assign idx_b = bus.address_port_b[AW-1:0];
    assign in_a = {1'b0, bus.address_port_a} < LIMIT;
    assign in_b = {1'b0, bus.address_port_b} < LIMIT;
    assign rd_a = ready && bus.enable_port_a && !bus.write_port_a;
    assign rd_b = ready && bus.enable_port_b && !bus.write_port_b;
    assign wr_a = ready && bus.enable_port_a && bus.write_port_a && in_a;
    assign wr_b = ready && bus.enable_port_b && bus.write_port_b && in_b;
    assign coll = ready && bus.enable_port_a && bus.enable_port_b && in_a &&
                  bus.address_port_a == bus.address_port_b &&
                  (bus.write_port_a || bus.write_port_b);
    assign aerr = ready && ((bus.enable_port_a && !in_a) || (bus.enable_port_b && !in_b));
    assign old_a = mem[idx_a];
    assign old_b = mem[idx_b];
    // a reader only sees the other port's merged word on a collision in write-first mode
    assign rdat_a = !in_a ? '0 : WRITE_FIRST != 0 && coll ?
                    merge(old_a, bus.data_in_port_b, bus.byte_en_port_b) : old_a;
    assign rdat_b = !in_b ? '0 : WRITE_FIRST != 0 && coll ?
                    merge(old_b, bus.data_in_port_a, bus.byte_en_port_a) : old_b;

    // port A is written last so it wins bytes that both ports enable
    always_ff @(posedge clk)
        if (state == CLEAR) mem[cnt] <= '0;
        else
            for (int i = 0; i < NB; i++) begin
                if (wr_b && bus.byte_en_port_b[i]) mem[idx_b][i*8 +: 8] <= bus.data_in_port_b[i*8 +: 8];
                if (wr_a && bus.byte_en_port_a[i]) mem[idx_a][i*8 +: 8] <= bus.data_in_port_a[i*8 +: 8];
            end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            {v1_a, v1_b, c1, e1, v2_a, v2_b, c2, e2} <= '0;
            {d1_a, d1_b, d2_a, d2_b} <= '0;
        end else begin
            {v1_a, v1_b, c1, e1} <= {rd_a, rd_b, coll, aerr};
            {v2_a, v2_b, c2, e2} <= {v1_a, v1_b, c1, e1};
            if (rd_a) d1_a <= rdat_a;
            if (rd_b) d1_b <= rdat_b;
            if (v1_a) d2_a <= d1_a;
            if (v1_b) d2_b <= d1_b;
        end

    assign bus.data_out_port_a = READ_LATENCY == 2 ? d2_a : d1_a;
    assign bus.data_out_port_b = READ_LATENCY == 2 ? d2_b : d1_b;
    assign bus.rd_valid_port_a = READ_LATENCY == 2 ? v2_a : v1_a;
    assign bus.rd_valid_port_b = READ_LATENCY == 2 ? v2_b : v1_b;
    assign bus.collision = READ_LATENCY == 2 ? c2 : c1;
    assign bus.addr_err = READ_LATENCY == 2 ? e2 : e1;
endmodule

// File: tb/tb_dpram_param.sv
// tb_dpram_param: two dpram_param instances (latency 1 / read-old, latency 2 / write-first)
// driven in lockstep and checked against a word-array reference model
module tb_dpram_param;
    localparam int DW = 128, AWD = 8, DEPTH = 16, NB = DW / 8;
    typedef struct packed {
        logic ea, wa; logic [NB-1:0] bea; logic [AWD-1:0] aa; logic [DW-1:0] da;
        logic eb, wb; logic [NB-1:0] beb; logic [AWD-1:0] ab; logic [DW-1:0] db;
    } op_t;
    typedef struct packed {logic va, vb, coll, aerr; logic [DW-1:0] da, db;} res_t;
    typedef struct {op_t op; logic chk; logic [DW-1:0] e0, e1;} vec_t;

    logic clk = 0, rst_n = 0;
    int n_vec = 0, n_bad = 0, post = 0;
    logic [DW-1:0] mem [DEPTH];
    res_t q1, p1, p2;
    vec_t tbl [9];

    dpram_if #(.DATA_W(DW), .ADDR_W(AWD)) b1 (), b2 ();
    always #5 clk = ~clk;
    assign b2.enable_port_a = b1.enable_port_a;
    assign b2.enable_port_b = b1.enable_port_b;
    assign b2.write_port_a = b1.write_port_a;
    assign b2.write_port_b = b1.write_port_b;
    assign b2.byte_en_port_a = b1.byte_en_port_a;
    assign b2.byte_en_port_b = b1.byte_en_port_b;
    assign b2.address_port_a = b1.address_port_a;
    assign b2.address_port_b = b1.address_port_b;
    assign b2.data_in_port_a = b1.data_in_port_a;
    assign b2.data_in_port_b = b1.data_in_port_b;

    dpram_param #(.DATA_W(DW), .ADDR_W(AWD), .DEPTH(DEPTH), .READ_LATENCY(1),
                  .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    dpram_param #(.DATA_W(DW), .ADDR_W(AWD), .DEPTH(DEPTH), .READ_LATENCY(2),
                  .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    function automatic op_t mk(input logic ea, wa, input logic [NB-1:0] bea, input logic [AWD-1:0] aa,
                               input logic [DW-1:0] da, input logic eb, wb, input logic [NB-1:0] beb,
                               input logic [AWD-1:0] ab, input logic [DW-1:0] db);
        mk = '{ea, wa, bea, aa, da, eb, wb, beb, ab, db};
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.ea = 1'($urandom); o.wa = 1'($urandom); o.bea = NB'($urandom);
        o.aa = AWD'($urandom_range(0, 19));
        o.da = {$urandom, $urandom, $urandom, $urandom};
        o.eb = 1'($urandom); o.wb = 1'($urandom); o.beb = NB'($urandom);
        o.ab = $urandom_range(0, 2) == 0 ? o.aa : AWD'($urandom_range(0, 19));
        o.db = {$urandom, $urandom, $urandom, $urandom};
        return o;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input op_t o);
        b1.enable_port_a = o.ea; b1.write_port_a = o.wa; b1.byte_en_port_a = o.bea;
        b1.address_port_a = o.aa; b1.data_in_port_a = o.da;
        b1.enable_port_b = o.eb; b1.write_port_b = o.wb; b1.byte_en_port_b = o.beb;
        b1.address_port_b = o.ab; b1.data_in_port_b = o.db;
    endtask

    // reference: r0 is the read-old view, r1 the write-first view of the same request
    task automatic step(input op_t o, input logic acc);
        res_t r0, r1;
        logic ina, inb, coll;
        logic [DW-1:0] oa, ob;
        drive(o);
        r0 = q1; r1 = p1;
        {r0.va, r0.vb, r0.coll, r0.aerr} = '0;
        {r1.va, r1.vb, r1.coll, r1.aerr} = '0;
        if (acc) begin
            ina = o.aa < DEPTH;
            inb = o.ab < DEPTH;
            oa = ina ? mem[o.aa[3:0]] : '0;
            ob = inb ? mem[o.ab[3:0]] : '0;
            coll = o.ea && o.eb && ina && o.aa == o.ab && (o.wa || o.wb);
            for (int i = 0; i < NB; i++)
                if (o.eb && o.wb && inb && o.beb[i]) mem[o.ab[3:0]][i*8 +: 8] = o.db[i*8 +: 8];
            for (int i = 0; i < NB; i++)
                if (o.ea && o.wa && ina && o.bea[i]) mem[o.aa[3:0]][i*8 +: 8] = o.da[i*8 +: 8];
            r0.coll = coll; r1.coll = coll;
            r0.aerr = (o.ea && !ina) || (o.eb && !inb); r1.aerr = r0.aerr;
            if (o.ea && !o.wa) begin
                r0.va = 1; r0.da = oa; r1.va = 1; r1.da = coll ? mem[o.aa[3:0]] : oa;
            end
            if (o.eb && !o.wb) begin
                r0.vb = 1; r0.db = ob; r1.vb = 1; r1.db = coll ? mem[o.ab[3:0]] : ob;
            end
        end
        p2 = p1; p1 = r1; q1 = r0;
    endtask

    task automatic cycle(input op_t o);
        @(negedge clk);
        if (post < DEPTH) post++;
        chk("busy d1", b1.busy, post < DEPTH);
        chk("busy d2", b2.busy, post < DEPTH);
        chk("rd_valid_a d1", b1.rd_valid_port_a, q1.va);
        chk("rd_valid_b d1", b1.rd_valid_port_b, q1.vb);
        chk("data_out_a d1", b1.data_out_port_a, q1.da);
        chk("data_out_b d1", b1.data_out_port_b, q1.db);
        chk("collision d1", b1.collision, q1.coll);
        chk("addr_err d1", b1.addr_err, q1.aerr);
        chk("rd_valid_a d2", b2.rd_valid_port_a, p2.va);
        chk("rd_valid_b d2", b2.rd_valid_port_b, p2.vb);
        chk("data_out_a d2", b2.data_out_port_a, p2.da);
        chk("data_out_b d2", b2.data_out_port_b, p2.db);
        chk("collision d2", b2.collision, p2.coll);
        chk("addr_err d2", b2.addr_err, p2.aerr);
        step(o, post >= DEPTH);
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("rst data_out d1", {b1.data_out_port_a, b1.data_out_port_b} == '0, 1'b1);
        chk("rst data_out d2", {b2.data_out_port_a, b2.data_out_port_b} == '0, 1'b1);
        chk("rst flags d1", {b1.rd_valid_port_a, b1.rd_valid_port_b, b1.collision, b1.addr_err, b1.busy}, 5'b00001);
        chk("rst flags d2", {b2.rd_valid_port_a, b2.rd_valid_port_b, b2.collision, b2.addr_err, b2.busy}, 5'b00001);
        q1 = '0; p1 = '0; p2 = '0; post = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        repeat (hold) @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        tbl[0] = '{mk(1, 1, '1, 5, {16{8'hAA}}, 0, 0, 0, 0, 0), 0, '0, '0};
        tbl[1] = '{mk(0, 0, 0, 0, 0, 1, 0, 0, 5, 0), 1, {16{8'hAA}}, {16{8'hAA}}};
        tbl[2] = '{mk(1, 1, '1, 7, {16{8'h55}}, 0, 0, 0, 0, 0), 0, '0, '0};
        tbl[3] = '{mk(1, 1, '1, 7, {16{8'h66}}, 1, 0, 0, 7, 0), 1, {16{8'h55}}, {16{8'h66}}};
        tbl[4] = '{mk(1, 1, 16'h00FF, 3, {16{8'h11}}, 1, 1, 16'hFFFF, 3, {16{8'h22}}), 0, '0, '0};
        tbl[5] = '{mk(0, 0, 0, 0, 0, 1, 0, 0, 3, 0), 1, {{8{8'h22}}, {8{8'h11}}}, {{8{8'h22}}, {8{8'h11}}}};
        tbl[6] = '{mk(1, 1, '1, 17, {16{8'hFF}}, 1, 0, 0, 20, 0), 1, '0, '0};
        tbl[7] = '{mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0), 1, '0, '0};
        tbl[8] = '{mk(0, 0, 0, 0, 0, 1, 0, 0, 7, 0), 1, {16{8'h66}}, {16{8'h66}}};
        drive('0);
        do_reset(2);
        repeat (DEPTH) cycle(rand_op());
        for (int i = 0; i < DEPTH + 4; i++) cycle(mk(1, 0, 0, AWD'(i), 0, 1, 0, 0, AWD'(i + 3), 0));
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].op);
            cycle('0);
            cycle('0);
            if (tbl[i].chk) begin
                chk($sformatf("tbl%0d data_out_b d1", i), b1.data_out_port_b, tbl[i].e0);
                chk($sformatf("tbl%0d data_out_b d2", i), b2.data_out_port_b, tbl[i].e1);
            end
        end
        repeat (400) cycle(rand_op());
        do_reset(1);
        repeat (7) cycle(rand_op());
        do_reset(1);
        repeat (DEPTH + 200) cycle(rand_op());
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
